// File: rtl/mbgd_pkg.sv
// mbgd_pkg: shared FSM encoding and pipeline-depth constants for the phase-1 blocks.
package mbgd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int MBGD_LAT = 3;
    localparam int MBGD_TOT = MBGD_LAT + 1;

    // One extra stage for the synchronous sample-memory read ahead of the datapath.
    function automatic int tot_of(input int lat);
        return lat + 1;
    endfunction

endpackage

// File: rtl/mbgd_valid_pipe.sv
// mbgd_valid_pipe: DEPTH-deep valid shift register that advances only when en is high.
module mbgd_valid_pipe #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] v_q, v_d;

    always_comb begin
        v_d = v_q;
        if (en) begin
            v_d[0] = din;
            for (int i = 1; i < DEPTH; i++) v_d[i] = v_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) v_q <= '0;
        else         v_q <= v_d;
    end

    assign dout = v_q[DEPTH-1];

endmodule

// File: rtl/mbgd_phase1_ctrl.sv
// mbgd_phase1_ctrl: issues one mini-batch of sample reads into the phase-1 datapath
// and writes the returning sigmoid results to the result buffer, with global hold.
module mbgd_phase1_ctrl
    import mbgd_pkg::*;
#(
    parameter int DW        = 8,
    parameter int BATCH     = 16,
    parameter int BATCH_BIT = 4,
    parameter int LAT       = MBGD_LAT
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 hold,
    output logic                 smp_rd,
    output logic [BATCH_BIT-1:0] smp_addr,
    output logic                 dp_enable,
    input  logic [DW-1:0]        dp_h,
    output logic                 res_we,
    output logic [BATCH_BIT-1:0] res_addr,
    output logic [DW-1:0]        res_data,
    output logic                 busy,
    output logic                 done
);

    localparam int TOT = tot_of(LAT);
    localparam logic [BATCH_BIT:0] LAST = (BATCH_BIT+1)'(BATCH - 1);

    state_e             state_q, state_d;
    logic [BATCH_BIT:0] rd_cnt_q, rd_cnt_d;
    logic [BATCH_BIT:0] wr_cnt_q, wr_cnt_d;
    logic               v_out;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Busy-state transitions only fire on a strobe, so hold freezes them implicitly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = (smp_rd && rd_cnt_q == LAST) ? ST_DRAIN : ST_ISSUE;
            ST_DRAIN: state_d = (res_we && wr_cnt_q == LAST) ? ST_DONE : ST_DRAIN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_cnt_d = smp_rd ? rd_cnt_q + 1'b1 : rd_cnt_q;
        wr_cnt_d = res_we ? wr_cnt_q + 1'b1 : wr_cnt_q;
        if (state_q == ST_IDLE && start) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end
    end

    always_comb begin
        busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
        dp_enable = busy && !hold;
        smp_rd    = (state_q == ST_ISSUE) && !hold;
        res_we    = v_out && dp_enable;
        done      = (state_q == ST_DONE);
        smp_addr  = rd_cnt_q[BATCH_BIT-1:0];
        res_addr  = wr_cnt_q[BATCH_BIT-1:0];
        res_data  = resetn ? dp_h : '0;
    end

    mbgd_valid_pipe #(.DEPTH(TOT)) u_valid_pipe (
        .clk    (clk),
        .resetn (resetn),
        .en     (dp_enable),
        .din    (smp_rd),
        .dout   (v_out)
    );

endmodule

// File: tb/tb_mbgd_phase1_ctrl.sv
// tb_mbgd_phase1_ctrl: directed scenarios for the phase-1 controller with a
// bench-side datapath model that tags each result with its sample address.
module tb_mbgd_phase1_ctrl;

    logic       clk = 1'b0;
    logic       resetn, start, hold;
    logic       smp_rd, dp_enable, res_we, busy, done;
    logic [3:0] smp_addr, res_addr;
    logic [7:0] dp_h, res_data;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mbgd_phase1_ctrl #(.DW(8), .BATCH(16), .BATCH_BIT(4), .LAT(3)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .hold      (hold),
        .smp_rd    (smp_rd),
        .smp_addr  (smp_addr),
        .dp_enable (dp_enable),
        .dp_h      (dp_h),
        .res_we    (res_we),
        .res_addr  (res_addr),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done)
    );

    // Datapath model: 4 enabled stages from read to result, carrying the address.
    logic       pv [4];
    logic [3:0] pa [4];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= 4'd0;
            end
        end else if (dp_enable) begin
            pv[0] <= smp_rd;
            pa[0] <= smp_addr;
            for (int i = 1; i < 4; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

    assign dp_h = 8'hA0 + {4'h0, pa[3]};

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    int rd_n, rd_first, rd_last, wr_n, wr_first, wr_last, done_n, done_c, busy_n;
    int ord_err, dpe_err, hold_err, rst_err, mem_err, rd_seq, wr_seq;
    int rd_at [40];
    logic [7:0] mem [16];

    task automatic run(input string name, input int hs, input int he, input int st2,
                       input int rs, input int re,
                       input int e_rd_n, input int e_rd_l, input int e_wr_n, input int e_wr_f,
                       input int e_wr_l, input int e_done, input int e_busy);
        rd_n = 0; rd_first = -1; rd_last = -1; wr_n = 0; wr_first = -1; wr_last = -1;
        done_n = 0; done_c = -1; busy_n = 0;
        ord_err = 0; dpe_err = 0; hold_err = 0; rst_err = 0; mem_err = 0;
        rd_seq = 0; wr_seq = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        for (int c = 0; c < 40; c++) begin
            rd_at[c] = -1;
            start  = (c == 0) || (c == st2);
            hold   = (c >= hs) && (c <= he);
            resetn = !((c >= rs) && (c <= re));
            @(negedge clk);
            if (!resetn) begin
                if ({smp_rd, smp_addr, dp_enable, res_we, res_addr, res_data, busy, done} != 0)
                    rst_err++;
                rd_seq = 0;
                wr_seq = 0;
            end
            if (dp_enable != (busy && !hold)) dpe_err++;
            if (hold && (smp_rd || res_we)) hold_err++;
            if (smp_rd) begin
                if (rd_first < 0) rd_first = c;
                rd_last = c;
                rd_at[c] = int'(smp_addr);
                if (int'(smp_addr) != rd_seq) ord_err++;
                rd_seq++;
                rd_n++;
            end
            if (res_we) begin
                if (wr_first < 0) wr_first = c;
                wr_last = c;
                if (int'(res_addr) != wr_seq || res_data != 8'hA0 + 8'(wr_seq)) ord_err++;
                mem[res_addr] = res_data;
                wr_seq++;
                wr_n++;
            end
            if (done) begin
                done_n++;
                done_c = c;
            end
            if (busy) busy_n++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        hold  = 1'b0;
        for (int i = 0; i < 16; i++) if (mem[i] != 8'hA0 + 8'(i)) mem_err++;
        chk({name, ".rd_n"},     rd_n,     e_rd_n);
        chk({name, ".rd_first"}, rd_first, 1);
        chk({name, ".rd_last"},  rd_last,  e_rd_l);
        chk({name, ".wr_n"},     wr_n,     e_wr_n);
        chk({name, ".wr_first"}, wr_first, e_wr_f);
        chk({name, ".wr_last"},  wr_last,  e_wr_l);
        chk({name, ".done_n"},   done_n,   1);
        chk({name, ".done_cyc"}, done_c,   e_done);
        chk({name, ".busy_n"},   busy_n,   e_busy);
        chk({name, ".order"},    ord_err,  0);
        chk({name, ".dp_en"},    dpe_err,  0);
        chk({name, ".hold_strb"}, hold_err, 0);
        chk({name, ".mem"},      mem_err,  0);
        if (rs <= re) begin
            chk({name, ".rst_outs"}, rst_err, 0);
            chk({name, ".restart_addr"}, rd_at[st2+1], 0);
        end
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        hold   = 1'b0;
        #2;
        chk("reset_outs", int'({smp_rd, smp_addr, dp_enable, res_we, res_addr, res_data, busy, done}), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        //         name        hs  he  st2 rs  re  rd_n rd_l wr_n wr_f wr_l done busy
        run("nominal",        99, 0,  0,  99, 0,  16,  16,  16,  5,   20,  21,  20);
        run("hold_issue",     6,  8,  0,  99, 0,  16,  19,  16,  5,   23,  24,  23);
        run("hold_drain",     18, 19, 0,  99, 0,  16,  16,  16,  5,   22,  23,  22);
        run("start_busy",     99, 0,  10, 99, 0,  16,  16,  16,  5,   20,  21,  20);
        run("reset_mid",      99, 0,  15, 12, 14, 27,  31,  23,  5,   35,  36,  31);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
